// File: rtl/edge_arb_pkg.sv
// -----------------------------------------------------------------------------
// edge_arb_pkg
//   Shared definitions for the edge_event_arbiter codebase slice.
//   - arb_state_t      : arbiter FSM states (IDLE, OFFER)
//   - EDGE_ARB_MAX_CH  : largest supported channel count
//   - rr_pick()        : round-robin winner search over a pending vector
//
//   rr_pick(pending, last, n_ch):
//     Returns the first set bit of pending[n_ch-1:0] strictly after index
//     'last', wrapping modulo n_ch. 'last' itself is considered last in
//     order. If nothing is pending, 'last' is returned unchanged, so callers
//     must check for a non-zero vector first.
// -----------------------------------------------------------------------------
package edge_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned EDGE_ARB_MAX_CH   = 16;
  localparam int unsigned EDGE_ARB_MAX_ID_W = $clog2(EDGE_ARB_MAX_CH);

  function automatic logic [EDGE_ARB_MAX_ID_W-1:0] rr_pick(
    input logic [EDGE_ARB_MAX_CH-1:0]   pending,
    input logic [EDGE_ARB_MAX_ID_W-1:0] last,
    input int unsigned                  n_ch
  );
    logic [EDGE_ARB_MAX_ID_W-1:0] pick;
    logic                         found;
    int unsigned                  idx;
    logic [EDGE_ARB_MAX_ID_W-1:0] idx_w;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= EDGE_ARB_MAX_CH; k++) begin
      // Wrap by subtraction: last < n_ch and k <= n_ch, so one subtraction
      // suffices and no divider is needed.
      idx = 32'(last) + k;
      if (idx >= n_ch) begin
        idx = idx - n_ch;
      end
      idx_w = idx[EDGE_ARB_MAX_ID_W-1:0];
      if (!found && (k <= n_ch) && pending[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage : edge_arb_pkg

// File: rtl/edge_arb_chan.sv
// -----------------------------------------------------------------------------
// edge_arb_chan
//   One input channel of the edge event arbiter: optional input synchroniser,
//   rising-edge detector, pending-event latch and sticky overflow flag.
//
//   Configuration macro: EDGE_ARB_SYNC_EN
//     defined   -> i_din passes through a 2-flop synchroniser (reset 0)
//     undefined -> i_din feeds the detector directly (must be synchronous)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     i_din      in   level input of this channel
//     i_en       in   capture enable for new events
//     i_clr      in   handshake clear of this channel's pending event
//     i_ovf_clr  in   synchronous clear of the overflow flag
//     o_pending  out  latched, not-yet-accepted event
//     o_overflow out  sticky event-lost flag
// -----------------------------------------------------------------------------
module edge_arb_chan
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_ovf_clr,
  output logic o_pending,
  output logic o_overflow
);

  logic w_din;
  logic w_rise;
  logic r_prev;
  logic r_pending;
  logic r_overflow;

`ifdef EDGE_ARB_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din = r_sync2;
`else
  assign w_din = i_din;
`endif

  // prev follows the input regardless of enable, so enabling a channel
  // while its line is already high does not manufacture an edge.
  assign w_rise = w_din & ~r_prev & i_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_prev <= w_din;

      // A new edge wins over a same-cycle handshake clear: the old event is
      // consumed and the new one stays latched.
      if (w_rise) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end

      // Loss only when an unconsumed event is overwritten; a set beats the
      // bulk clear in the same cycle.
      if (w_rise && r_pending && !i_clr) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule : edge_arb_chan

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//   Multi-channel rising-edge event scheduler. Each of N_CH inputs latches a
//   pending event on a rising edge; a round-robin arbiter serialises pending
//   events to one consumer over a valid/ready handshake. Per-channel sticky
//   overflow flags report events lost while a previous one was unserved.
//
//   Configuration macro: EDGE_ARB_SYNC_EN (see edge_arb_chan) adds a 2-flop
//   input synchroniser per channel, adding 2 cycles to all latencies.
//
//   Parameters
//     N_CH   number of channels (2..16)
//     ID_W   derived channel-index width, $clog2(N_CH)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     din        in   [N_CH]  level inputs
//     en         in   [N_CH]  per-channel capture enable
//     evt_valid  out          event offered to consumer
//     evt_id     out  [ID_W]  channel index of offered event
//     evt_ready  in           consumer accepts offered event
//     pending    out  [N_CH]  latched, not-yet-accepted events
//     overflow   out  [N_CH]  sticky per-channel event-lost flags
//     ovf_clr    in           synchronous clear of all overflow bits
// -----------------------------------------------------------------------------
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] din,
  input  logic [N_CH-1:0] en,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow,
  input  logic            ovf_clr
);

  arb_state_t      r_state;
  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last;

  logic            w_hs;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_pending;
  logic [N_CH-1:0] w_overflow;
  logic [N_CH-1:0] w_pend_others;

  assign w_hs = r_valid & evt_ready;

  always_comb begin
    w_clr = '0;
    if (w_hs) begin
      w_clr[r_id] = 1'b1;
    end
  end

  // Candidates for a back-to-back grant: the bit being accepted this cycle
  // is excluded even if a fresh edge keeps it latched; that new event is
  // served on a later round.
  assign w_pend_others = w_pending & ~w_clr;

  for (genvar g = 0; g < N_CH; g = g + 1) begin : g_chan
    edge_arb_chan u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_din      (din[g]),
      .i_en       (en[g]),
      .i_clr      (w_clr[g]),
      .i_ovf_clr  (ovf_clr),
      .o_pending  (w_pending[g]),
      .o_overflow (w_overflow[g])
    );
  end

  // last_grant resets to N_CH-1 so that channel 0 wins the first round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_last  <= ID_W'(N_CH - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pending) begin
            r_id    <= ID_W'(rr_pick(EDGE_ARB_MAX_CH'(w_pending),
                                     EDGE_ARB_MAX_ID_W'(r_last), N_CH));
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            r_last <= r_id;
            if (|w_pend_others) begin
              r_id <= ID_W'(rr_pick(EDGE_ARB_MAX_CH'(w_pend_others),
                                    EDGE_ARB_MAX_ID_W'(r_id), N_CH));
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign pending   = w_pending;
  assign overflow  = w_overflow;

endmodule : edge_event_arbiter
